// File: rtl/serial_sub_17bit_with_dff_if.sv
// Handshake and operand/result bundle for the digit-serial subtractor.
// The master drives start and operands; the slave returns status and the result.
interface serial_sub_17bit_with_dff_if #(
    parameter int W = 16
);
    logic         start;
    logic [W:0]   minuend;
    logic [W-1:0] subtrahend;
    logic         busy;
    logic         valid;
    logic [W:0]   diff;
    logic         borrow;

    modport master (
        output start,
        output minuend,
        output subtrahend,
        input  busy,
        input  valid,
        input  diff,
        input  borrow
    );

    modport slave (
        input  start,
        input  minuend,
        input  subtrahend,
        output busy,
        output valid,
        output diff,
        output borrow
    );
endinterface

// File: rtl/serial_sub_17bit_with_dff.sv
// Digit-serial subtractor recovering one addend from a registered adder sum:
// diff = minuend - subtrahend, STEP bits per clock, with a registered result.
module serial_sub_17bit_with_dff #(
    parameter int W    = 16,
    parameter int STEP = 4
) (
    input logic                          clk,
    input logic                          reset,
    serial_sub_17bit_with_dff_if.slave   bus
);
    localparam int NDIG = W / STEP;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   m_reg;
    logic [W-1:0]   s_reg;
    logic [W-1:0]   acc;
    logic           m_msb;
    logic           chain;
    logic           busy_r;
    logic           valid_r;
    logic           borrow_r;
    logic [W:0]     diff_r;

    logic [STEP:0]  dig_full;
    logic [STEP-1:0] dig;
    logic           dig_borrow;
    logic [W-1:0]   acc_next;

    // One digit of subtraction; the extra top bit of dig_full is the borrow-out.
    always_comb begin
        dig_full   = {1'b0, m_reg[STEP-1:0]} - {1'b0, s_reg[STEP-1:0]}
                   - {{STEP{1'b0}}, chain};
        dig        = dig_full[STEP-1:0];
        dig_borrow = dig_full[STEP];
        acc_next   = (acc >> STEP) | (W'(dig) << (W - STEP));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            m_reg    <= '0;
            s_reg    <= '0;
            acc      <= '0;
            m_msb    <= 1'b0;
            chain    <= 1'b0;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            borrow_r <= 1'b0;
            diff_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m_reg  <= bus.minuend[W-1:0];
                        m_msb  <= bus.minuend[W];
                        s_reg  <= bus.subtrahend;
                        chain  <= 1'b0;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Operands shift down so the current digit is always in the low bits.
                    m_reg <= m_reg >> STEP;
                    s_reg <= s_reg >> STEP;
                    acc   <= acc_next;
                    chain <= dig_borrow;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(NDIG - 1)) begin
                        diff_r   <= {m_msb ^ dig_borrow, acc_next};
                        borrow_r <= ~m_msb & dig_borrow;
                        valid_r  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.valid  = valid_r;
    assign bus.diff   = diff_r;
    assign bus.borrow = borrow_r;

endmodule

// File: tb/tb_serial_sub_17bit_with_dff.sv
// Self-checking bench for serial_sub_17bit_with_dff: directed and random
// operands compared against plain modular subtraction with a cycle-count model.
module tb_serial_sub_17bit_with_dff;
    localparam int W    = 16;
    localparam int STEP = 4;
    localparam int NDIG = W / STEP;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [W:0] last_diff;
    logic       last_borrow;

    serial_sub_17bit_with_dff_if #(.W(W)) bus ();

    serial_sub_17bit_with_dff #(.W(W), .STEP(STEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [W:0] observed, input logic [W:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [W:0] refDiff(input logic [W:0] m, input logic [W-1:0] s);
        return (W+1)'((m - {1'b0, s}) % (1 << (W + 1)));
    endfunction

    function automatic logic refBorrow(input logic [W:0] m, input logic [W-1:0] s);
        return (int'(m) < int'(s));
    endfunction

    // One complete operation from an idle DUT; optionally pulses start during DONE.
    task automatic applyStimulus(input logic [W:0] m, input logic [W-1:0] s, input bit done_start);
        bus.start      = 1'b1;
        bus.minuend    = m;
        bus.subtrahend = s;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.minuend    = (W+1)'($urandom);
        bus.subtrahend = W'($urandom);
        checkOutput("accept_busy", {16'd0, bus.busy}, 17'd1);
        checkOutput("accept_hold", bus.diff, last_diff);
        for (int k = 1; k <= NDIG; k++) begin
            @(posedge clk); #1;
            if (k < NDIG) begin
                checkOutput("run_valid", {16'd0, bus.valid}, 17'd0);
                checkOutput("run_hold", bus.diff, last_diff);
            end else begin
                checkOutput("done_valid", {16'd0, bus.valid}, 17'd1);
                checkOutput("done_busy", {16'd0, bus.busy}, 17'd1);
                checkOutput("diff", bus.diff, refDiff(m, s));
                checkOutput("borrow", {16'd0, bus.borrow}, {16'd0, refBorrow(m, s)});
                last_diff   = refDiff(m, s);
                last_borrow = refBorrow(m, s);
            end
        end
        if (done_start) begin
            bus.start = 1'b1;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        checkOutput("post_valid", {16'd0, bus.valid}, 17'd0);
        checkOutput("post_busy", {16'd0, bus.busy}, 17'd0);
        checkOutput("post_hold", bus.diff, last_diff);
        checkOutput("post_borrow", {16'd0, bus.borrow}, {16'd0, last_borrow});
        if (done_start) begin
            @(posedge clk); #1;
            checkOutput("done_start_ignored", {16'd0, bus.busy}, 17'd0);
        end
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   pend_m;
        logic [W-1:0] pend_s;
        int           wait_cnt;
        int           accepts;
        int           valids;

        checks      = 0;
        errors      = 0;
        last_diff   = '0;
        last_borrow = 1'b0;
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.minuend    = '0;
        bus.subtrahend = '0;

        // Reset held, then idle cycles with start low.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checkOutput("rst_busy", {16'd0, bus.busy}, 17'd0);
            checkOutput("rst_valid", {16'd0, bus.valid}, 17'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("idle_busy", {16'd0, bus.busy}, 17'd0);
            checkOutput("idle_valid", {16'd0, bus.valid}, 17'd0);
            checkOutput("idle_diff", bus.diff, 17'h00000);
            checkOutput("idle_borrow", {16'd0, bus.borrow}, 17'd0);
        end

        // Directed boundary cases.
        applyStimulus(17'h1FFFE, 16'hFFFF, 1'b0);
        applyStimulus(17'h00000, 16'h0001, 1'b0);
        applyStimulus(17'h12345, 16'h2345, 1'b0);
        applyStimulus(17'h0ABCD, 16'hABCD, 1'b1);

        // Random pairs: minuend is an adder sum, so the other addend comes back.
        for (int i = 0; i < 100; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            applyStimulus({1'b0, a} + {1'b0, b}, a, 1'b0);
            checkOutput("recover_addend", last_diff, {1'b0, b});
        end

        // start held high with fresh operands each cycle; accepted only when idle.
        wait_cnt = 0;
        accepts  = 0;
        valids   = 0;
        pend_m   = '0;
        pend_s   = '0;
        for (int i = 0; i < 36; i++) begin
            bus.start      = (i < 30);
            bus.minuend    = (W+1)'($urandom);
            bus.subtrahend = W'($urandom);
            @(posedge clk); #1;
            if (wait_cnt == 0) begin
                if (i < 30) begin
                    pend_m   = bus.minuend;
                    pend_s   = bus.subtrahend;
                    wait_cnt = NDIG + 1;
                    accepts++;
                end
            end else begin
                wait_cnt--;
            end
            checkOutput("stream_busy", {16'd0, bus.busy}, {16'd0, wait_cnt != 0});
            checkOutput("stream_valid", {16'd0, bus.valid}, {16'd0, wait_cnt == 1});
            if (wait_cnt == 1) begin
                valids++;
                checkOutput("stream_diff", bus.diff, refDiff(pend_m, pend_s));
                checkOutput("stream_borrow", {16'd0, bus.borrow}, {16'd0, refBorrow(pend_m, pend_s)});
                last_diff   = refDiff(pend_m, pend_s);
                last_borrow = refBorrow(pend_m, pend_s);
            end
        end
        bus.start = 1'b0;
        checkOutput("stream_count", 17'(valids), 17'(accepts));

        // Asynchronous reset two cycles into RUN discards the operation.
        bus.start      = 1'b1;
        bus.minuend    = 17'h1F0F0;
        bus.subtrahend = 16'h0F0F;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        checkOutput("async_busy", {16'd0, bus.busy}, 17'd0);
        checkOutput("async_valid", {16'd0, bus.valid}, 17'd0);
        checkOutput("async_diff", bus.diff, 17'h00000);
        checkOutput("async_borrow", {16'd0, bus.borrow}, 17'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checkOutput("inreset_valid", {16'd0, bus.valid}, 17'd0);
        end
        reset       = 1'b1;
        last_diff   = '0;
        last_borrow = 1'b0;
        for (int i = 0; i < NDIG + 2; i++) begin
            @(posedge clk); #1;
            checkOutput("postreset_valid", {16'd0, bus.valid}, 17'd0);
        end
        applyStimulus(17'h1F0F0, 16'h0F0F, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
